// File: rtl/mem_word_reader_pkg.sv
// Shared types and constants for the halfword-memory word reader.
package mem_word_reader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SLOT_N = 3;
    localparam int unsigned BUF_W  = HALF_W * SLOT_N;

    localparam logic ENDIAN_BIG    = 1'b0;
    localparam logic ENDIAN_LITTLE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Reverse byte order of a 32-bit word.
    function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mem_word_reader_assembler.sv
// Picks the four addressed bytes out of the slot buffer and applies endian order.
module word_assembler
    import mem_word_reader_pkg::*;
(
    input  logic [BUF_W-1:0]  slot_buf,
    input  logic              a0_lsb,
    input  logic              le,
    output logic [WORD_W-1:0] word_c
);

    logic [WORD_W-1:0] bytes_be;

    // Slot 0 sits in the top of the buffer, so the byte stream reads left to right.
    always_comb begin
        bytes_be = a0_lsb ? slot_buf[BUF_W-1-BYTE_W -: WORD_W]
                          : slot_buf[BUF_W-1 -: WORD_W];
        word_c   = (le == ENDIAN_LITTLE) ? byte_swap32(bytes_be) : bytes_be;
    end

endmodule

// File: rtl/mem_word_reader.sv
// Byte-addressed 32-bit word read sequencer over a 16-bit halfword memory.
module mem_word_reader
    import mem_word_reader_pkg::*;
#(
    parameter int unsigned BYTE_ADDR_W = 8,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [BYTE_ADDR_W-1:0] byte_addr,
    input  logic                   little_endian,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_W-1:0]      rd_word,
    output logic                   unaligned,
    output logic [BYTE_ADDR_W-2:0] mem_addr,
    input  logic [HALF_W-1:0]      mem_rd_data
);

    localparam int unsigned HADDR_W = BYTE_ADDR_W - 1;
    localparam int unsigned CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state, state_nxt;
    logic [HADDR_W-1:0]  h, h_nxt;
    logic                le_q, le_nxt;
    logic                unaligned_nxt;
    logic [1:0]          slot_idx, slot_idx_nxt;
    logic [BUF_W-1:0]    slot_buf, slot_buf_nxt;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
    logic [HADDR_W-1:0]  mem_addr_nxt;
    logic                busy_nxt, done_nxt;
    logic [WORD_W-1:0]   rd_word_nxt;
    logic [WORD_W-1:0]   asm_word_c;

    word_assembler u_asm (
        .slot_buf (slot_buf),
        .a0_lsb   (unaligned),
        .le       (le_q),
        .word_c   (asm_word_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            h         <= '0;
            le_q      <= ENDIAN_BIG;
            unaligned <= 1'b0;
            slot_idx  <= '0;
            slot_buf  <= '0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_word   <= '0;
        end else begin
            state     <= state_nxt;
            h         <= h_nxt;
            le_q      <= le_nxt;
            unaligned <= unaligned_nxt;
            slot_idx  <= slot_idx_nxt;
            slot_buf  <= slot_buf_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_word   <= rd_word_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        h_nxt         = h;
        le_nxt        = le_q;
        unaligned_nxt = unaligned;
        slot_idx_nxt  = slot_idx;
        slot_buf_nxt  = slot_buf;
        wait_cnt_nxt  = wait_cnt;
        mem_addr_nxt  = mem_addr;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        rd_word_nxt   = rd_word;

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    h_nxt         = byte_addr[BYTE_ADDR_W-1:1];
                    le_nxt        = little_endian;
                    unaligned_nxt = byte_addr[0];
                    slot_idx_nxt  = '0;
                    slot_buf_nxt  = '0;
                    busy_nxt      = 1'b1;
                    state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr_nxt = h;
                wait_cnt_nxt = '0;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                case (slot_idx)
                    2'd0:    slot_buf_nxt[BUF_W-1 -: HALF_W]          = mem_rd_data;
                    2'd1:    slot_buf_nxt[BUF_W-1-HALF_W -: HALF_W]   = mem_rd_data;
                    default: slot_buf_nxt[HALF_W-1:0]                 = mem_rd_data;
                endcase
                // Unaligned words straddle three halfwords, aligned ones two.
                if (slot_idx == (unaligned ? 2'd2 : 2'd1)) begin
                    state_nxt = S_DONE;
                end else begin
                    h_nxt        = h + HADDR_W'(1);
                    slot_idx_nxt = slot_idx + 2'd1;
                    state_nxt    = S_ISSUE;
                end
            end
            S_DONE: begin
                rd_word_nxt = asm_word_c;
                done_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
